// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the shared data-memory port arbiter:
//   NUM_HART     number of requesting harts
//   HART_W       hart-index width (derived from NUM_HART)
//   data_t       32-bit address/data word, NULL is its all-zero value
//   arb_state_t  arbiter FSM states
//   idx_to_oh()  hart index -> one-hot hart vector
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int NUM_HART = 2;
    localparam int HART_W   = (NUM_HART > 1) ? $clog2(NUM_HART) : 1;

    typedef logic [31:0]         data_t;
    typedef logic [HART_W-1:0]   hart_idx_t;
    typedef logic [NUM_HART-1:0] hart_vec_t;

    localparam data_t NULL = '0;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_RESP
    } arb_state_t;

    function automatic hart_vec_t idx_to_oh(hart_idx_t idx);
        hart_vec_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the per-hart MEM-stage handshake, the shared memory port and the
// store-snoop broadcast.
//   master : the arbiter (takes hart requests and memory completions, drives
//            grants/completions, the memory request and the snoop)
//   slave  : the environment (harts + memory), the mirror image
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    // hart side
    hart_vec_t                hart_req;
    hart_vec_t                hart_wr;
    data_t [NUM_HART-1:0]     hart_addr;
    data_t [NUM_HART-1:0]     hart_wdata;
    hart_vec_t                hart_gnt;
    hart_vec_t                hart_done;
    data_t                    hart_rdata;

    // memory side
    logic                     mem_req;
    logic                     mem_wr;
    data_t                    mem_addr;
    data_t                    mem_wdata;
    logic                     mem_ack;
    data_t                    mem_rdata;

    // store snoop broadcast
    logic                     snoop_valid;
    data_t                    snoop_addr;
    hart_idx_t                snoop_src;

    modport master (
        input  hart_req, hart_wr, hart_addr, hart_wdata, mem_ack, mem_rdata,
        output hart_gnt, hart_done, hart_rdata,
               mem_req, mem_wr, mem_addr, mem_wdata,
               snoop_valid, snoop_addr, snoop_src
    );

    modport slave (
        output hart_req, hart_wr, hart_addr, hart_wdata, mem_ack, mem_rdata,
        input  hart_gnt, hart_done, hart_rdata,
               mem_req, mem_wr, mem_addr, mem_wdata,
               snoop_valid, snoop_addr, snoop_src
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts one past
// last_winner and wraps modulo N; the first requester found wins.
// Ports:
//   req          in   N       request vector
//   last_winner  in   IDX_W   index of the previous winner
//   grant_oh     out  N       one-hot winner (all zero when no request)
//   grant_idx    out  IDX_W   winner index (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_winner,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] cand;

    function automatic logic [IDX_W-1:0] wrap_idx(int unsigned base, int unsigned off);
        int unsigned sum;
        sum = (base + off) % N;
        return sum[IDX_W-1:0];
    endfunction

    // Walk the candidates from farthest to nearest so the nearest requester
    // is the last one written and therefore the one that sticks.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = N; i >= 1; i--) begin
            cand = wrap_idx(32'(last_winner), i);
            if (req[cand]) begin
                grant_oh       = '0;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin arbiter that serialises the harts' loads/stores (LR/SC included)
// onto one shared data-memory port, and broadcasts each committed store as a
// one-cycle snoop so the other harts can drop matching reservations.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   bus    mem_port_arbiter_if.master
//          hart_req/wr/addr/wdata -> hart_gnt/done/rdata (one-hot pulses)
//          mem_req/wr/addr/wdata  <- mem_ack/mem_rdata
//          snoop_valid/addr/src   store commit broadcast
// Flow: IDLE -> ISSUE (until mem_ack) -> RESP (one cycle) -> IDLE.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    mem_port_arbiter_if.master     bus
);

    arb_state_t state_q,       state_d;
    hart_idx_t  last_winner_q, last_winner_d;
    hart_idx_t  win_q,         win_d;
    logic       wr_q,          wr_d;
    data_t      addr_q,        addr_d;
    data_t      wdata_q,       wdata_d;
    data_t      rdata_q,       rdata_d;
    logic       gnt_pend_q,    gnt_pend_d;   // high only in the first ISSUE cycle

    hart_vec_t  pick_oh;
    hart_idx_t  pick_idx;

    rr_arbiter #(.N(NUM_HART)) u_rr (
        .req         (bus.hart_req),
        .last_winner (last_winner_q),
        .grant_oh    (pick_oh),
        .grant_idx   (pick_idx)
    );

    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        win_d         = win_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        gnt_pend_d    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Only the winner's request fields are captured.
                if (|pick_oh) begin
                    win_d         = pick_idx;
                    last_winner_d = pick_idx;
                    wr_d          = bus.hart_wr[pick_idx];
                    addr_d        = bus.hart_addr[pick_idx];
                    wdata_d       = bus.hart_wdata[pick_idx];
                    gnt_pend_d    = 1'b1;
                    state_d       = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.mem_ack) begin
                    // Stores return NULL so stale read data never leaks out.
                    rdata_d = wr_q ? NULL : bus.mem_rdata;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together
    // from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            last_winner_q <= hart_idx_t'(NUM_HART - 1);
            // NOTE: the datapath registers are reset too, so an aborted
            // transaction leaves nothing behind that a later RESP could expose.
            win_q         <= '0;
            wr_q          <= 1'b0;
            addr_q        <= NULL;
            wdata_q       <= NULL;
            rdata_q       <= NULL;
            gnt_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            win_q         <= win_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            gnt_pend_q    <= gnt_pend_d;
        end
    end

    // Outputs are register values qualified by the registered state, so they
    // are glitch-free, held through memory wait states and zero elsewhere.
    logic in_issue;
    logic in_resp;
    logic snoop_hit;

    assign in_issue  = (state_q == ARB_ISSUE);
    assign in_resp   = (state_q == ARB_RESP);
    assign snoop_hit = in_resp & wr_q;

    assign bus.hart_gnt    = gnt_pend_q ? idx_to_oh(win_q) : '0;
    assign bus.hart_done   = in_resp    ? idx_to_oh(win_q) : '0;
    assign bus.hart_rdata  = in_resp    ? rdata_q : NULL;

    assign bus.mem_req     = in_issue;
    assign bus.mem_wr      = in_issue & wr_q;
    assign bus.mem_addr    = in_issue ? addr_q  : NULL;
    assign bus.mem_wdata   = in_issue ? wdata_q : NULL;

    assign bus.snoop_valid = snoop_hit;
    assign bus.snoop_addr  = snoop_hit ? addr_q : NULL;
    assign bus.snoop_src   = snoop_hit ? win_q  : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus pushes hand-computed grant/done/snoop/memory expectations
// into queues; an independent negedge monitor pops and compares whenever the
// arbiter presents one of those outputs. A separate memory responder answers
// mem_req after a programmable number of wait states.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // cycle n is the interval following the n-th rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int    hart;
        data_t val;
        int    cyc;
    } exp_t;

    typedef struct {
        logic  wr;
        data_t addr;
        data_t wdata;
    } mem_exp_t;

    exp_t     gnt_exp[$];
    exp_t     done_exp[$];
    exp_t     snoop_exp[$];
    mem_exp_t mem_exp[$];

    // memory responder controls (written by stimulus only)
    int    mem_waits    = 0;
    data_t mem_data     = NULL;
    logic  spurious_ack = 1'b0;

    // hart0 exclusive-monitor model (written by monitor only)
    logic  resv_valid = 1'b0;
    data_t resv_addr  = NULL;
    logic  lr_pending = 1'b0;
    data_t lr_addr    = NULL;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(string name, logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h, expected no output (cycle %0d)", name, act, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------ memory
    initial begin
        int wcnt;
        wcnt          = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = NULL;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = NULL;
            if (spurious_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hBAD0_BAD0;
            end else if (bus.mem_req) begin
                if (wcnt == mem_waits) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_data;
                    wcnt          = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ----------------------------------------------------------------- monitor
    initial begin
        exp_t     e;
        mem_exp_t m;
        forever begin
            @(negedge clk);
            if (bus.hart_gnt != '0) begin
                if (gnt_exp.size() == 0) unexpected("gnt_extra", 32'(bus.hart_gnt));
                else begin
                    e = gnt_exp.pop_front();
                    check("gnt_vec", 32'(bus.hart_gnt), 32'(1) << e.hart);
                    check("gnt_cycle", cyc, e.cyc);
                end
            end
            if (bus.hart_done != '0) begin
                if (done_exp.size() == 0) unexpected("done_extra", 32'(bus.hart_done));
                else begin
                    e = done_exp.pop_front();
                    check("done_vec", 32'(bus.hart_done), 32'(1) << e.hart);
                    check("done_rdata", bus.hart_rdata, e.val);
                    check("done_cycle", cyc, e.cyc);
                    if (e.hart == 0 && lr_pending) begin
                        resv_valid = 1'b1;
                        resv_addr  = lr_addr;
                    end
                end
            end
            if (bus.snoop_valid) begin
                if (snoop_exp.size() == 0) unexpected("snoop_extra", bus.snoop_addr);
                else begin
                    e = snoop_exp.pop_front();
                    check("snoop_addr", bus.snoop_addr, e.val);
                    check("snoop_src", 32'(bus.snoop_src), e.hart);
                    check("snoop_cycle", cyc, e.cyc);
                end
                // hart0's monitor: remote store to the reserved line, or its own SC
                if (bus.snoop_src != '0 && bus.snoop_addr == resv_addr) resv_valid = 1'b0;
                if (bus.snoop_src == '0) resv_valid = 1'b0;
            end
            if (bus.mem_req && bus.mem_ack) begin
                if (mem_exp.size() == 0) unexpected("mem_extra", bus.mem_addr);
                else begin
                    m = mem_exp.pop_front();
                    check("mem_wr", 32'(bus.mem_wr), 32'(m.wr));
                    check("mem_addr", bus.mem_addr, m.addr);
                    check("mem_wdata", bus.mem_wdata, m.wdata);
                end
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic check_outputs_zero(string tag);
        check({tag, "_gnt"},         32'(bus.hart_gnt),    0);
        check({tag, "_done"},        32'(bus.hart_done),   0);
        check({tag, "_rdata"},       bus.hart_rdata,       0);
        check({tag, "_mem_req"},     32'(bus.mem_req),     0);
        check({tag, "_mem_wr"},      32'(bus.mem_wr),      0);
        check({tag, "_mem_addr"},    bus.mem_addr,         0);
        check({tag, "_mem_wdata"},   bus.mem_wdata,        0);
        check({tag, "_snoop_valid"}, 32'(bus.snoop_valid), 0);
        check({tag, "_snoop_addr"},  bus.snoop_addr,       0);
        check({tag, "_snoop_src"},   32'(bus.snoop_src),   0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check_outputs_zero("reset");
        tick();
        rst_n = 1'b1;
    endtask

    // One hart, one transaction. Request raised in cycle c: grant in c+1,
    // ack after `waits` wait states, done (and snoop for stores) in c+2+waits.
    task automatic single(int h, logic wr, data_t addr, data_t wdata,
                          int waits, data_t rdata, bit toggle_other);
        int c;
        int other;
        c     = cyc;
        other = (h + 1) % NUM_HART;
        mem_waits = waits;
        mem_data  = rdata;
        bus.hart_req[h]   = 1'b1;
        bus.hart_wr[h]    = wr;
        bus.hart_addr[h]  = addr;
        bus.hart_wdata[h] = wdata;
        gnt_exp.push_back('{h, NULL, c + 1});
        mem_exp.push_back('{wr, addr, wdata});
        done_exp.push_back('{h, wr ? NULL : rdata, c + 2 + waits});
        if (wr) snoop_exp.push_back('{h, addr, c + 2 + waits});
        tick();
        bus.hart_req[h] = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            check("mem_req_held",   32'(bus.mem_req), 1);
            check("mem_wr_held",    32'(bus.mem_wr), 32'(wr));
            check("mem_addr_held",  bus.mem_addr, addr);
            check("mem_wdata_held", bus.mem_wdata, wdata);
            if (toggle_other) bus.hart_req[other] = (k < waits) ? ~bus.hart_req[other] : 1'b0;
            tick();
        end
        check("mem_req_dropped", 32'(bus.mem_req), 0);
        tick();
    endtask

    // Both harts request continuously; assumes last winner is hart NUM_HART-1,
    // so grants alternate 0,1,0,1 three cycles apart.
    task automatic both_burst(int ntx);
        int c;
        c         = cyc;
        mem_waits = 0;
        mem_data  = 32'h1234_5678;
        for (int h = 0; h < NUM_HART; h++) begin
            bus.hart_req[h]   = 1'b1;
            bus.hart_wr[h]    = 1'b0;
            bus.hart_addr[h]  = 32'h1000 * (h + 1);
            bus.hart_wdata[h] = 32'hA0 + h;
        end
        for (int t = 0; t < ntx; t++) begin
            gnt_exp.push_back('{t % 2, NULL, c + 1 + 3 * t});
            mem_exp.push_back('{1'b0, 32'h1000 * (t % 2 + 1), 32'hA0 + t % 2});
            done_exp.push_back('{t % 2, 32'h1234_5678, c + 2 + 3 * t});
        end
        for (int k = 0; k < 3 * (ntx - 1) + 1; k++) tick();
        bus.hart_req = '0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst_n          = 1'b0;
        bus.hart_req   = '0;
        bus.hart_wr    = '0;
        for (int h = 0; h < NUM_HART; h++) begin
            bus.hart_addr[h]  = 32'hFFFF_0000 + h;
            bus.hart_wdata[h] = 32'hEEEE_0000 + h;
        end

        // 1: zero-wait load by hart0
        do_reset();
        single(0, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD, 1'b0);

        // 2: hart1 store with three wait states, snoop in RESP
        single(1, 1'b1, 32'h200, 32'h5, 3, 32'h0, 1'b0);

        // 3: both harts from reset, continuously
        do_reset();
        both_burst(4);

        // 4: LR/SC reservation killed by a remote store, then a successful pair
        lr_pending = 1'b1;
        lr_addr    = 32'h300;
        single(0, 1'b0, 32'h300, 32'h0, 0, 32'h77, 1'b0);
        lr_pending = 1'b0;
        check("lr_reserved", 32'(resv_valid), 1);
        single(1, 1'b1, 32'h300, 32'h9, 1, 32'h0, 1'b0);
        check("sc_fails_after_snoop", 32'(resv_valid), 0);
        lr_pending = 1'b1;
        lr_addr    = 32'h340;
        single(0, 1'b0, 32'h340, 32'h0, 0, 32'h88, 1'b0);
        lr_pending = 1'b0;
        single(1, 1'b1, 32'h380, 32'hB, 0, 32'h0, 1'b0);
        check("resv_kept_other_addr", 32'(resv_valid), 1);
        single(0, 1'b1, 32'h340, 32'hC, 0, 32'h0, 1'b0);
        check("own_sc_clears_resv", 32'(resv_valid), 0);

        // 5: reset while ISSUE holds mem_req; last winner returns to NUM_HART-1
        c = cyc;
        mem_waits = 10;
        bus.hart_req[0]  = 1'b1;
        bus.hart_wr[0]   = 1'b0;
        bus.hart_addr[0] = 32'h500;
        gnt_exp.push_back('{0, NULL, c + 1});
        tick();
        bus.hart_req[0] = 1'b0;
        tick();
        check("mem_req_before_abort", 32'(bus.mem_req), 1);
        rst_n = 1'b0;
        tick();
        check_outputs_zero("abort");
        rst_n = 1'b1;
        tick();
        tick();
        both_burst(2);
        single(1, 1'b0, 32'h520, 32'h0, 0, 32'h5151, 1'b0);

        // 6: spurious ack in IDLE, other hart toggling its request in ISSUE
        spurious_ack = 1'b1;
        tick();
        spurious_ack = 1'b0;
        check("spurious_no_req",  32'(bus.mem_req), 0);
        check("spurious_no_done", 32'(bus.hart_done), 0);
        tick();
        single(0, 1'b0, 32'h600, 32'h66, 3, 32'h6666, 1'b1);

        tick();
        tick();
        check("gnt_queue_empty",   gnt_exp.size(),   0);
        check("done_queue_empty",  done_exp.size(),  0);
        check("snoop_queue_empty", snoop_exp.size(), 0);
        check("mem_queue_empty",   mem_exp.size(),   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
